// File: rtl/dsm_stereo_decimator.sv
// Stereo sigma-delta receiver: synchronises two 1-bit streams, boxcar-decimates each by
// 2^AUDIO_BITS and hands packed unsigned PCM samples out through a one-deep buffer.
module dsm_stereo_decimator #(
  parameter int unsigned AUDIO_BITS = 12
) (
  input  logic                    clk,
  input  logic                    aclr_,
  input  logic                    enable,
  input  logic                    left_in,
  input  logic                    right_in,
  input  logic                    rreq,
  input  logic                    clear_overrun,
  output logic [2*AUDIO_BITS-1:0] sample,
  output logic                    valid,
  output logic                    overrun,
  output logic                    frame_tick
);

  localparam int unsigned N = AUDIO_BITS;
  localparam logic [N-1:0] CntOne = 1;

  typedef enum logic [0:0] {StStartup, StRun} state_e;

  state_e         state_q, state_d;
  logic           l_meta_q, l_bit_q, r_meta_q, r_bit_q;
  logic [N-1:0]   frame_cnt_q, frame_cnt_d;
  logic [N:0]     acc_l_q, acc_l_d, acc_r_q, acc_r_d;
  logic [2*N-1:0] sample_q, sample_d;
  logic           valid_q, valid_d;
  logic           overrun_q, overrun_d;
  logic           frame_tick_q, frame_tick_d;

  logic           boundary, publish;
  logic [N:0]     total_l, total_r;

  // A full frame of ones (2^N) does not fit in N bits; clamp it to full scale.
  function automatic logic [N-1:0] sat(input logic [N:0] t);
    sat = t[N] ? '1 : t[N-1:0];
  endfunction

  always_comb begin
    state_d      = state_q;
    frame_cnt_d  = frame_cnt_q + CntOne;
    acc_l_d      = acc_l_q;
    acc_r_d      = acc_r_q;
    sample_d     = sample_q;
    valid_d      = valid_q;
    overrun_d    = overrun_q;

    total_l      = acc_l_q + {{N{1'b0}}, l_bit_q};
    total_r      = acc_r_q + {{N{1'b0}}, r_bit_q};
    boundary     = enable && (frame_cnt_q == {N{1'b1}});
    publish      = boundary && (state_q == StRun);
    frame_tick_d = boundary;

    if (!enable) begin
      state_d     = StStartup;
      frame_cnt_d = '0;
      acc_l_d     = '0;
      acc_r_d     = '0;
    end else if (boundary) begin
      // The first frame after startup carries synchroniser fill and is dropped.
      state_d = StRun;
      acc_l_d = '0;
      acc_r_d = '0;
    end else begin
      acc_l_d = total_l;
      acc_r_d = total_r;
    end

    if (publish) begin
      sample_d = {sat(total_l), sat(total_r)};
      valid_d  = 1'b1;
    end else if (rreq) begin
      valid_d = 1'b0;
    end

    if (publish && valid_q && !rreq) begin
      overrun_d = 1'b1;
    end else if (clear_overrun) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge aclr_) begin
    if (!aclr_) begin
      state_q      <= StStartup;
      l_meta_q     <= 1'b0;
      l_bit_q      <= 1'b0;
      r_meta_q     <= 1'b0;
      r_bit_q      <= 1'b0;
      frame_cnt_q  <= '0;
      acc_l_q      <= '0;
      acc_r_q      <= '0;
      sample_q     <= '0;
      valid_q      <= 1'b0;
      overrun_q    <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      l_meta_q     <= left_in;
      l_bit_q      <= l_meta_q;
      r_meta_q     <= right_in;
      r_bit_q      <= r_meta_q;
      frame_cnt_q  <= frame_cnt_d;
      acc_l_q      <= acc_l_d;
      acc_r_q      <= acc_r_d;
      sample_q     <= sample_d;
      valid_q      <= valid_d;
      overrun_q    <= overrun_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign sample     = sample_q;
  assign valid      = valid_q;
  assign overrun    = overrun_q;
  assign frame_tick = frame_tick_q;

endmodule
